// File: rtl/soc_system_led_pwm.sv
// Two-channel LED PWM dimmer with per-LED blink gating, controlled over a
// zero-wait-state Avalon-MM slave (CTRL, DUTY, PERIOD, STATUS).
module soc_system_led_pwm #(
    parameter int unsigned PRESCALE = 500
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [1:0]  led_in,
    output logic [1:0]  led_out
);
    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    logic        enable_q, enable_d;
    logic [1:0]  blink_en_q, blink_en_d;
    logic [15:0] duty_sh_q, duty_sh_d;
    logic [15:0] duty_act_q, duty_act_d;
    logic [15:0] period_q, period_d;
    logic [15:0] presc_q, presc_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        phase_q, phase_d;
    logic [1:0]  led_out_q, led_out_d;

    logic        wr_en;
    logic        tick;
    logic        frame_end;
    logic [7:0]  duty_i;
    logic        unused_wdata;

    assign wr_en        = chipselect && !write_n;
    assign tick         = (presc_q == PS_LAST);
    assign frame_end    = tick && (pwm_cnt_q == 8'hFF);
    assign unused_wdata = ^writedata[31:16];

    always_comb begin
        enable_d    = enable_q;
        blink_en_d  = blink_en_q;
        duty_sh_d   = duty_sh_q;
        period_d    = period_q;
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;

        if (wr_en && address == 2'd0) begin
            enable_d   = writedata[8];
            blink_en_d = writedata[1:0];
        end
        if (wr_en && address == 2'd1) begin
            duty_sh_d = writedata[15:0];
        end
        if (wr_en && address == 2'd2) begin
            period_d = writedata[15:0];
        end

        presc_d    = tick ? 16'd0 : presc_q + 16'd1;
        pwm_cnt_d  = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        // New duties only take effect at a frame boundary so a frame is never split.
        duty_act_d = frame_end ? duty_sh_q : duty_act_q;

        // A PERIOD write restarts the blink window and overrides a coincident frame end.
        if (wr_en && address == 2'd2) begin
            frame_cnt_d = 16'd0;
            phase_d     = 1'b1;
        end else if (period_q == 16'd0) begin
            frame_cnt_d = 16'd0;
            phase_d     = 1'b1;
        end else if (frame_end) begin
            if (frame_cnt_q == period_q - 16'd1) begin
                frame_cnt_d = 16'd0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        led_out_d = 2'b00;
        duty_i    = 8'd0;
        for (int i = 0; i < 2; i++) begin
            duty_i       = duty_act_q[i*8 +: 8];
            led_out_d[i] = enable_q && led_in[i]
                           && ((pwm_cnt_q < duty_i) || (duty_i == 8'hFF))
                           && (!blink_en_q[i] || phase_q);
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0:    readdata = {23'd0, enable_q, 6'd0, blink_en_q};
            2'd1:    readdata = {16'd0, duty_sh_q};
            2'd2:    readdata = {16'd0, period_q};
            default: readdata = {23'd0, phase_q, pwm_cnt_q};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q    <= 1'b0;
            blink_en_q  <= 2'b00;
            duty_sh_q   <= 16'd0;
            duty_act_q  <= 16'd0;
            period_q    <= 16'd0;
            presc_q     <= 16'd0;
            pwm_cnt_q   <= 8'd0;
            frame_cnt_q <= 16'd0;
            phase_q     <= 1'b1;
            led_out_q   <= 2'b00;
        end else begin
            enable_q    <= enable_d;
            blink_en_q  <= blink_en_d;
            duty_sh_q   <= duty_sh_d;
            duty_act_q  <= duty_act_d;
            period_q    <= period_d;
            presc_q     <= presc_d;
            pwm_cnt_q   <= pwm_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
            led_out_q   <= led_out_d;
        end
    end

    assign led_out = led_out_q;

endmodule

// File: tb/tb_soc_system_led_pwm.sv
// Directed bench for soc_system_led_pwm with PRESCALE=4 (4 clk per tick,
// 1024 clk per PWM frame); cyc counts rising edges since the last reset release.
module tb_soc_system_led_pwm;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  led_in;
    logic [1:0]  led_out;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    soc_system_led_pwm #(.PRESCALE(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .led_in     (led_in),
        .led_out    (led_out)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        address = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    // Walk to cycle hi, requiring led_out == exp at every cycle on the way.
    task automatic run_check(input int hi, input logic [1:0] exp, input string tag);
        int bad = 0;
        while (cyc < hi) begin
            step();
            if (led_out !== exp) bad++;
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        led_in     = 2'b00;

        repeat (3) @(negedge clk);
        chk("led_in_reset", {30'd0, led_out}, 32'd0);
        reset_n = 1'b1;
        cyc     = 0;
        rd(2'd0, 32'h0,   "rst_ctrl");
        rd(2'd1, 32'h0,   "rst_duty");
        rd(2'd2, 32'h0,   "rst_period");
        rd(2'd3, 32'h100, "rst_status");
        chk("rst_led", {30'd0, led_out}, 32'd0);

        led_in = 2'b11;
        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd0, 32'h103, "ctrl_mask");
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, 32'h100, "status_ro");
        wr(2'd0, 32'h100);
        wr(2'd1, 32'h40);
        rd(2'd1, 32'h40,  "duty_rd");
        rd(2'd0, 32'h100, "ctrl_rd");
        rd(2'd2, 32'h0,   "period_rd");

        // Duty 0x40: high for k in [1025,1280] of each 1024-clk frame.
        run_check(1024, 2'b00, "pre_first_frame");
        run_check(1280, 2'b01, "duty64_high");
        run_check(2048, 2'b00, "duty64_low");
        run_check(2304, 2'b01, "frame3_high");
        run_check(2448, 2'b00, "frame3_low");
        rd(2'd3, 32'h164, "status_pwm100");

        wr(2'd1, 32'hFF00);
        rd(2'd1, 32'hFF00, "duty_shadow");
        run_check(3072, 2'b00, "duty_buffered");
        run_check(4096, 2'b10, "duty_0_255");

        wr(2'd1, 32'h00FF);
        wr(2'd0, 32'h101);
        wr(2'd2, 32'h2);
        rd(2'd2, 32'h2, "period_rd2");
        address = 2'd3;
        run_check(5120, 2'b10, "blink_pre_load");
        run_check(6143, 2'b01, "blink_on1");
        rd(2'd3, 32'h1FF, "status_6143");
        run_check(6144, 2'b01, "blink_on1_end");
        rd(2'd3, 32'h000, "status_6144");
        run_check(8191, 2'b00, "blink_off");
        rd(2'd3, 32'h0FF, "status_8191");
        run_check(8192, 2'b00, "blink_off_end");
        rd(2'd3, 32'h100, "status_8192");
        run_check(10240, 2'b01, "blink_on2");
        run_check(10500, 2'b00, "blink_off2");
        rd(2'd3, 32'h041, "status_10500");

        wr(2'd2, 32'h2);
        chk("period_wr_led_lag", {30'd0, led_out}, 32'd0);
        rd(2'd3, 32'h141, "period_wr_phase");
        step();
        chk("period_wr_led", {30'd0, led_out}, 32'd1);

        run_check(10600, 2'b01, "steady_on");
        led_in = 2'b10;
        step();
        chk("led_in_drop", {30'd0, led_out}, 32'd0);
        led_in = 2'b11;
        step();
        chk("led_in_back", {30'd0, led_out}, 32'd1);
        wr(2'd0, 32'h001);
        chk("enable_drop_lag", {30'd0, led_out}, 32'd1);
        step();
        chk("enable_drop", {30'd0, led_out}, 32'd0);
        rd(2'd3, 32'h15B, "counters_run_disabled");
        rd(2'd0, 32'h001, "ctrl_disabled");
        wr(2'd0, 32'h101);
        chk("enable_back_lag", {30'd0, led_out}, 32'd0);
        step();
        chk("enable_back", {30'd0, led_out}, 32'd1);
        run_check(10610, 2'b01, "pre_reset_on");

        #3;
        reset_n = 1'b0;
        #1;
        chk("async_reset_led", {30'd0, led_out}, 32'd0);
        rd(2'd0, 32'h0,   "mid_rst_ctrl");
        rd(2'd1, 32'h0,   "mid_rst_duty");
        rd(2'd3, 32'h100, "mid_rst_status");
        @(negedge clk);
        @(negedge clk);
        chk("held_reset_led", {30'd0, led_out}, 32'd0);
        reset_n = 1'b1;
        cyc     = 0;
        run_check(8, 2'b00, "post_reset_off");
        rd(2'd3, 32'h102, "post_reset_status");
        rd(2'd2, 32'h0,   "post_reset_period");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/soc_system_led_pwm.md
SOC_SYSTEM_LED_PWM -- requirements
Module: soc_system_led_pwm

Interface
REQ-001 SHALL have parameter PRESCALE, default 500: clk cycles per PWM tick (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  system clock; all state sampled on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port address  input  2  Avalon-MM word address.
REQ-005 SHALL have port chipselect  input  1  slave select.
REQ-006 SHALL have port write_n  input  1  active-low write strobe.
REQ-007 SHALL have port writedata  input  32  write data.
REQ-008 SHALL have port readdata  output  32  combinational read data; zero-extended.
REQ-009 SHALL have port led_in  input  2  per-LED on request, driven by the LED PIO out_port.
REQ-010 SHALL have port led_out  output  2  registered LED drive to pins.

Function
REQ-011 SHALL accept a write when chipselect=1 and write_n=0; zero wait states; registers update on that rising edge.
REQ-012 SHALL implement addr0 CTRL (RW): bit8 enable, bits[1:0] blink_en per LED; other bits read 0.
REQ-013 SHALL implement addr1 DUTY (RW): bits[7:0] duty0, bits[15:8] duty1; reads return last-written shadow values.
REQ-014 SHALL implement addr2 PERIOD (RW): bits[15:0] blink half-period in PWM frames.
REQ-015 SHALL implement addr3 STATUS (RO): bits[7:0] pwm_cnt, bit8 blink phase; writes ignored.
REQ-016 SHALL drive readdata = selected register for the current address, independent of chipselect.
REQ-017 SHALL run a prescaler counting 0..PRESCALE-1 and wrapping to 0; tick=1 for the one cycle the count equals PRESCALE-1.
REQ-018 SHALL increment 8-bit pwm_cnt on each tick, wrapping 255->0; frame_end = tick AND pwm_cnt==255.
REQ-019 SHALL copy DUTY shadows into active duty registers only on frame_end; no mid-frame duty change.
REQ-020 SHALL count frames on frame_end; when the frame count reaches PERIOD-1, SHALL toggle phase and clear the count.
REQ-021 SHALL hold phase=1 and the frame count at 0 while PERIOD==0.
REQ-022 SHALL, on a PERIOD write, clear the frame count and set phase=1 in the same edge; the write wins over a coincident frame_end.
REQ-023 SHALL compute on[i] = enable AND led_in[i] AND (pwm_cnt < active_duty[i] OR active_duty[i]==255) AND (NOT blink_en[i] OR phase).
REQ-024 SHALL register led_out[i] <= on[i]; led_out lags the inputs by exactly one clk.
REQ-025 SHALL keep counters running while enable=0; enable gates only led_out.
REQ-026 SHALL give duty 0 an always-off output and duty 255 an always-on output; duty d otherwise gives d high ticks per 256-tick frame.

Reset
REQ-027 SHALL, while reset_n=0, force CTRL, DUTY shadows, active duties, PERIOD, prescaler, pwm_cnt, frame count and led_out to 0, and phase to 1.
REQ-028 SHALL, on reset assertion mid-frame, clear led_out asynchronously with no further toggles; operation restarts from pwm_cnt=0 after release.

Verification (PRESCALE=4)
REQ-029 SHALL verify reset: after release, readdata=0 at addr0..2, readdata=0x100 at addr3, led_out=2'b00.
REQ-030 SHALL verify PWM: CTRL=0x100, DUTY=0x0040, led_in=2'b11 -> after the first frame_end, led_out[0] high for 64 ticks (256 clk) per 1024-clk frame, led_out[1]=0.
REQ-031 SHALL verify the duty boundary: DUTY=0xFF00 -> led_out[1] constantly 1 and led_out[0] constantly 0 from the next frame onward.
REQ-032 SHALL verify duty buffering: a DUTY write at pwm_cnt=100 leaves led_out unchanged until pwm_cnt wraps to 0.
REQ-033 SHALL verify blink: CTRL=0x101, PERIOD=2 -> led_out[0] gated off for alternating 2-frame windows, with STATUS bit8 toggling every 2048 clk; a PERIOD write mid-window restores phase=1 on the next cycle.
REQ-034 SHALL verify gating: led_in or enable dropping to 0 -> the matching led_out falls exactly one clk later; reset_n pulsed low mid-frame -> led_out=0 immediately.
